// File: rtl/mfp_pkg.sv
// Shared types and encodings for the MFP USART transmitter.
package mfp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  typedef enum logic [1:0] {
    WL_8 = 2'b00,
    WL_7 = 2'b01,
    WL_6 = 2'b10,
    WL_5 = 2'b11
  } wlen_e;

  typedef enum logic [1:0] {
    SM_SYNC = 2'b00,
    SM_ONE  = 2'b01,
    SM_ONE5 = 2'b10,
    SM_TWO  = 2'b11
  } stop_e;

  localparam int TSR_BE  = 7;
  localparam int TSR_EOT = 4;
  localparam int TSR_BRK = 3;
  localparam int TSR_TE  = 0;

  typedef struct packed {
    logic  div16;
    wlen_e wlen;
    stop_e stop;
    logic  par_en;
  } tx_cfg_t;

  function automatic logic [2:0] last_bit(wlen_e wl);
    return 3'd7 - 3'(wl);
  endfunction

  function automatic logic calc_parity(logic [7:0] d, wlen_e wl, logic even);
    logic [7:0] m;
    m = 8'hFF >> wl;
    return (^(d & m)) ^ ~even;
  endfunction

endpackage

// File: rtl/mfp_usart_tx.sv
// MFP USART transmitter: holding register, shifter and framing FSM
// clocked by qualified timer-D pulses.
module mfp_usart_tx
  import mfp_pkg::*;
#(
  parameter int DIV_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       tc,
  input  logic [6:0] ucr,
  input  logic       tx_en,
  input  logic       brk,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       so,
  output logic       buf_empty,
  output logic       eot,
  output logic       tx_irq
);

  localparam logic [DIV_LOG2-1:0] PRE_LAST = '1;
  localparam logic [DIV_LOG2-1:0] PRE_HALF = PRE_LAST >> 1;

  tx_state_e           state, nxt;
  tx_cfg_t             cfg;
  logic [DIV_LOG2-1:0] presc;
  logic [2:0]          cnt;
  logic [7:0]          shifter, hold;
  logic                par_bit;
  logic                tick, bit_done, stop_end, transfer, enter_brk, restart, ucr_ok;

  assign tick     = clk_en & tc;
  assign bit_done = tick & (~cfg.div16 | (presc == PRE_LAST));
  assign ucr_ok   = ucr[3:2] != 2'b00;
  assign restart  = (nxt != state) | transfer;

  // 1.5 stop bits under div16 ends half way through the second stop bit
  always_comb begin
    if (cfg.div16 && cfg.stop == SM_ONE5)
      stop_end = tick && cnt == 3'd1 && presc == PRE_HALF;
    else
      stop_end = bit_done && cnt == ((cfg.stop == SM_ONE) ? 3'd0 : 3'd1);
  end

  always_comb begin
    nxt       = state;
    transfer  = 1'b0;
    enter_brk = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_en && !buf_empty && ucr_ok) begin
          if (tick) begin
            transfer = 1'b1;
            nxt      = ST_START;
          end
        end else if (clk_en && tx_en && brk) begin
          enter_brk = 1'b1;
          nxt       = ST_BREAK;
        end
      end
      ST_START:  if (bit_done) nxt = ST_DATA;
      ST_DATA:   if (bit_done && cnt == last_bit(cfg.wlen)) nxt = cfg.par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) nxt = ST_STOP;
      ST_STOP: begin
        if (stop_end) begin
          if (tx_en && !buf_empty && ucr_ok) begin
            transfer = 1'b1;
            nxt      = ST_START;
          end else begin
            nxt = ST_IDLE;
          end
        end
      end
      ST_BREAK:  if (clk_en && !(brk && tx_en)) nxt = ST_STOP;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    so = 1'b1;
    case (state)
      ST_START:  so = 1'b0;
      ST_DATA:   so = shifter[0];
      ST_PARITY: so = par_bit;
      ST_BREAK:  so = 1'b0;
      default:   so = 1'b1;
    endcase
  end

  assign tx_irq = transfer;
  assign eot    = !tx_en && state == ST_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cfg       <= '0;
      presc     <= '0;
      cnt       <= '0;
      shifter   <= '0;
      par_bit   <= 1'b0;
      hold      <= '0;
      buf_empty <= 1'b1;
    end else begin
      state <= nxt;
      if (restart)                presc <= '0;
      else if (tick && cfg.div16) presc <= presc + 1'b1;

      if (restart) cnt <= '0;
      else if (bit_done && (state == ST_DATA || state == ST_STOP)) cnt <= cnt + 3'd1;

      // configuration is frozen for the whole character at the transfer
      if (transfer) begin
        shifter <= hold;
        par_bit <= calc_parity(hold, wlen_e'(ucr[5:4]), ucr[0]);
        cfg     <= '{div16: ucr[6], wlen: wlen_e'(ucr[5:4]), stop: stop_e'(ucr[3:2]), par_en: ucr[1]};
      end else if (state == ST_DATA && bit_done) begin
        shifter <= shifter >> 1;
      end
      if (enter_brk)
        cfg <= '{div16: ucr[6], wlen: WL_8, stop: SM_ONE, par_en: 1'b0};

      // a write coinciding with the transfer refills holding
      if (clk_en && wr) begin
        hold      <= din;
        buf_empty <= 1'b0;
      end else if (transfer) begin
        buf_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mfp_usart_tx.sv
// Bench for mfp_usart_tx: per-tick line samples compared against a frame model.
module tb_mfp_usart_tx;

  logic       clk = 1'b0, reset = 1'b1, clk_en = 1'b1, tc = 1'b0;
  logic       tx_en = 1'b0, brk = 1'b0, wr = 1'b0;
  logic [6:0] ucr = '0;
  logic [7:0] din = '0;
  logic       so, buf_empty, eot, tx_irq;

  int total = 0, bad = 0, irq_cnt = 0;
  bit exp_q[$];
  bit obs_q[$];

  mfp_usart_tx #(.DIV_LOG2(4)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .tc(tc), .ucr(ucr), .tx_en(tx_en),
    .brk(brk), .wr(wr), .din(din), .so(so), .buf_empty(buf_empty), .eot(eot),
    .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (tx_irq) irq_cnt <= irq_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one entry per tc pulse: the line level held during that tick interval
  function automatic void add_char(input logic [6:0] u, input logic [7:0] d);
    int bt, nb, ns;
    bit p;
    bt = u[6] ? 16 : 1;
    nb = 8 - int'(u[5:4]);
    p  = 1'b0;
    repeat (bt) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      p ^= d[i];
      repeat (bt) exp_q.push_back(d[i]);
    end
    if (u[1]) repeat (bt) exp_q.push_back(u[0] ? p : !p);
    case (u[3:2])
      2'b01:   ns = bt;
      2'b10:   ns = u[6] ? 24 : 2;
      default: ns = 2 * bt;
    endcase
    repeat (ns) exp_q.push_back(1'b1);
  endfunction

  task automatic wr_byte(input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic run(input int n, input int wr_at, input logic [7:0] wd, input int b_on, input int b_off);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_q.push_back(so);
      tc = 1'b1;
      if (i == wr_at) begin wr = 1'b1; din = wd; end
      if (i == b_on)  brk = 1'b1;
      if (i == b_off) brk = 1'b0;
      @(negedge clk);
      tc = 1'b0; wr = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_stream(input string tag);
    int b0;
    for (int i = 0; i < obs_q.size(); i++) begin
      b0 = bad;
      chk($sformatf("%s[%0d]", tag, i), 32'(obs_q[i]), (i < exp_q.size()) ? 32'(exp_q[i]) : 32'd1);
      if (bad != b0) break;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic xmit(input string tag, input logic [6:0] u, input logic [7:0] d);
    int i0;
    ucr = u;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back(1'b1);
    add_char(u, d);
    i0 = irq_cnt;
    run(exp_q.size() + 4, -1, 8'h00, -1, -1);
    check_stream(tag);
    chk({tag, "_irq"}, irq_cnt - i0, 1);
    chk({tag, "_be"}, buf_empty, 1);
  endtask

  task automatic send(input string tag, input logic [6:0] u, input logic [7:0] d);
    ucr = u;
    wr_byte(d);
    xmit(tag, u, d);
  endtask

  initial begin
    int i0;
    logic [6:0] u;
    #12;
    chk("rst_so", so, 1); chk("rst_be", buf_empty, 1);
    chk("rst_eot", eot, 1); chk("rst_irq", tx_irq, 0);
    @(negedge clk) reset = 1'b0;

    tx_en = 1'b1;
    send("8n1_55", 7'b0_00_01_0_0, 8'h55);
    send("d16_13", 7'b1_11_11_1_1, 8'h13);
    send("d16_1p5", 7'b1_10_10_0_0, 8'h2D);

    // back-to-back: second byte written while the first is in DATA
    ucr = 7'b0_01_11_1_0;
    wr_byte(8'hA0);
    exp_q.push_back(1'b1); add_char(ucr, 8'hA0); add_char(ucr, 8'h0F);
    i0 = irq_cnt;
    run(exp_q.size() + 4, 5, 8'h0F, -1, -1);
    check_stream("b2b");
    chk("b2b_irq", irq_cnt - i0, 2); chk("b2b_be", buf_empty, 1);

    // write in the same clk as the transfer
    tx_en = 1'b0; ucr = 7'b0_00_01_0_0;
    wr_byte(8'h3C);
    chk("same_be", buf_empty, 0);
    tx_en = 1'b1;
    exp_q.push_back(1'b1); add_char(ucr, 8'h3C); add_char(ucr, 8'hC5);
    i0 = irq_cnt;
    run(exp_q.size() + 4, 0, 8'hC5, -1, -1);
    check_stream("same");
    chk("same_irq", irq_cnt - i0, 2); chk("same_be2", buf_empty, 1);

    // overwrite while disabled
    tx_en = 1'b0;
    wr_byte(8'h11); wr_byte(8'h22);
    chk("ovw_be", buf_empty, 0); chk("ovw_eot1", eot, 1);
    @(negedge clk) tx_en = 1'b1;
    #1 chk("ovw_eot0", eot, 0);
    xmit("ovw", 7'b0_00_01_0_0, 8'h22);
    @(negedge clk) tx_en = 1'b0;
    #1 chk("ovw_eot2", eot, 1);
    tx_en = 1'b1;

    // break raised mid-character
    ucr = 7'b0_00_01_0_0;
    wr_byte(8'h00);
    exp_q.push_back(1'b1); add_char(ucr, 8'h00);
    repeat (5) exp_q.push_back(1'b0);
    run(exp_q.size() + 4, -1, 8'h00, 3, 15);
    check_stream("brk");

    // sync stop mode: nothing is taken
    ucr = 7'b0_00_00_0_0;
    wr_byte(8'h5A);
    i0 = irq_cnt;
    run(6, -1, 8'h00, -1, -1);
    check_stream("sync");
    chk("sync_be", buf_empty, 0); chk("sync_irq", irq_cnt - i0, 0);
    xmit("sync_go", 7'b0_11_01_1_0, 8'h5A);

    // tc without clk_en is ignored
    ucr = 7'b0_00_01_0_0;
    wr_byte(8'h81);
    clk_en = 1'b0;
    run(6, -1, 8'h00, -1, -1);
    check_stream("gate");
    chk("gate_be", buf_empty, 0);
    clk_en = 1'b1;
    xmit("gate_go", 7'b0_00_01_0_0, 8'h81);

    // asynchronous reset mid-DATA
    ucr = 7'b0_00_01_0_0;
    wr_byte(8'h00);
    exp_q.push_back(1'b1); add_char(ucr, 8'h00);
    run(5, -1, 8'h00, -1, -1);
    check_stream("pre_rst");
    chk("pre_rst_so", so, 0);
    tx_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_so", so, 1); chk("arst_be", buf_empty, 1); chk("arst_eot", eot, 1);
    @(negedge clk) reset = 1'b0;
    tx_en = 1'b1;
    send("after_rst", 7'b0_10_10_1_1, 8'hC3);

    for (int k = 0; k < 6; k++) begin
      u = 7'($urandom_range(0, 127));
      if (u[3:2] == 2'b00) u[2] = 1'b1;
      send($sformatf("rnd%0d", k), u, 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
